// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_pkg                                                 |
// | Brief  : Shared constants and write-source encoding for the RV32IM  |
// |          register-file write-port arbiter.                           |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package regfile_pkg;

    localparam int REG_COUNT    = 32;
    localparam int AW           = $clog2(REG_COUNT);
    localparam logic [AW-1:0] X0_ADDR = '0;
    localparam int STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_MAIN = 2'd1,
        WB_BUF  = 2'd2,
        WB_MDU  = 2'd3
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_scoreboard                                          |
// | Brief  : Busy bit per register with an outstanding MDU result; one  |
// |          set port, one clear port and two source lookups.            |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int REG_COUNT = 32,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_set_en,
    input  logic [AW-1:0]        i_set_addr,
    input  logic                 i_clr_en,
    input  logic [AW-1:0]        i_clr_addr,
    input  logic [AW-1:0]        i_rd_addr_a,
    input  logic [AW-1:0]        i_rd_addr_b,
    output logic                 o_rd_busy_a,
    output logic                 o_rd_busy_b,
    output logic [REG_COUNT-1:0] o_busy
);

    logic [REG_COUNT-1:0] r_busy;
    logic [REG_COUNT-1:0] w_set_mask;
    logic [REG_COUNT-1:0] w_clr_mask;

    // x0 is never marked, so every lookup of index 0 reads as free
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en && (i_set_addr != '0)) begin
            w_set_mask[i_set_addr] = 1'b1;
        end
        if (i_clr_en) begin
            w_clr_mask[i_clr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_rd_busy_a = r_busy[i_rd_addr_a];
    assign o_rd_busy_b = r_busy[i_rd_addr_b];
    assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_wb_arbiter                                          |
// | Brief  : Shares the register-file write port between writeback and  |
// |          the MDU, with a one-entry MDU buffer, starvation guard and  |
// |          hazard scoreboard. REGFILE_WB_FWD_EN adds rs1/rs2 forwarding.|
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter  int WIDTH        = 32,
    parameter  int REG_COUNT    = regfile_pkg::REG_COUNT,
    parameter  int STARVE_LIMIT = regfile_pkg::STARVE_LIMIT,
    localparam int AW           = $clog2(REG_COUNT)
) (
    input  logic                 CPU_clk,
    input  logic                 CPU_rst,
    input  logic                 main_we,
    input  logic [AW-1:0]        main_rd,
    input  logic [WIDTH-1:0]     main_wdata,
    input  logic                 mdu_issue,
    input  logic [AW-1:0]        mdu_issue_rd,
    input  logic                 mdu_valid,
    input  logic [AW-1:0]        mdu_rd,
    input  logic [WIDTH-1:0]     mdu_wdata,
    output logic                 mdu_ready,
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    output logic                 stall,
    output logic                 wb_hold,
    output logic                 RegWrite,
    output logic [AW-1:0]        RdAddr,
    output logic [WIDTH-1:0]     WriteData,
    output logic [REG_COUNT-1:0] busy
`ifdef REGFILE_WB_FWD_EN
    ,
    output logic                 rs1_fwd,
    output logic                 rs2_fwd
`endif
);

    localparam int c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0]      c_x0      = AW'(X0_ADDR);
    localparam logic [c_cnt_w-1:0] c_sat     = c_cnt_w'(STARVE_LIMIT);
    localparam logic [c_cnt_w-1:0] c_hold_at = c_cnt_w'(STARVE_LIMIT - 1);

    logic               r_buf_valid;
    logic [AW-1:0]      r_buf_rd;
    logic [WIDTH-1:0]   r_buf_wdata;
    logic [c_cnt_w-1:0] r_starve_cnt;

    wb_src_e            w_src;
    logic               w_main_eff;
    logic               w_mdu_req;
    logic               w_capture;
    logic               w_clr_en;
    logic [AW-1:0]      w_clr_addr;
    logic               w_rs1_busy;
    logic               w_rs2_busy;
    logic               w_rs1_stall;
    logic               w_rs2_stall;

    // A result addressed to x0 is accepted and dropped
    always_comb begin
        mdu_ready  = !r_buf_valid && !CPU_rst;
        w_main_eff = main_we && (main_rd != c_x0) && !CPU_rst;
        w_mdu_req  = mdu_valid && mdu_ready && (mdu_rd != c_x0);
        w_capture  = w_mdu_req && w_main_eff;
        w_src      = WB_NONE;
        if (CPU_rst) begin
            w_src = WB_NONE;
        end else if (w_main_eff) begin
            w_src = WB_MAIN;
        end else if (r_buf_valid) begin
            w_src = WB_BUF;
        end else if (w_mdu_req) begin
            w_src = WB_MDU;
        end
    end

    always_comb begin
        RegWrite   = 1'b0;
        RdAddr     = '0;
        WriteData  = '0;
        w_clr_en   = 1'b0;
        w_clr_addr = '0;
        case (w_src)
            WB_MAIN: begin
                RegWrite  = 1'b1;
                RdAddr    = main_rd;
                WriteData = main_wdata;
            end
            WB_BUF: begin
                RegWrite   = 1'b1;
                RdAddr     = r_buf_rd;
                WriteData  = r_buf_wdata;
                w_clr_en   = 1'b1;
                w_clr_addr = r_buf_rd;
            end
            WB_MDU: begin
                RegWrite   = 1'b1;
                RdAddr     = mdu_rd;
                WriteData  = mdu_wdata;
                w_clr_en   = 1'b1;
                w_clr_addr = mdu_rd;
            end
            default: begin
                RegWrite = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CPU_clk) begin
        if (CPU_rst) begin
            r_buf_valid  <= 1'b0;
            r_starve_cnt <= '0;
        end else if (w_src == WB_BUF) begin
            r_buf_valid  <= 1'b0;
            r_starve_cnt <= '0;
        end else if (w_capture) begin
            r_buf_valid  <= 1'b1;
        end else if (r_buf_valid && w_main_eff && (r_starve_cnt != c_sat)) begin
            r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge CPU_clk) begin
        if (w_capture) begin
            r_buf_rd    <= mdu_rd;
            r_buf_wdata <= mdu_wdata;
        end
    end

    assign wb_hold = (r_starve_cnt >= c_hold_at) && r_buf_valid && w_main_eff;

    regfile_scoreboard #(
        .REG_COUNT (REG_COUNT)
    ) u_scoreboard (
        .clk         (CPU_clk),
        .rst         (CPU_rst),
        .i_set_en    (mdu_issue),
        .i_set_addr  (mdu_issue_rd),
        .i_clr_en    (w_clr_en),
        .i_clr_addr  (w_clr_addr),
        .i_rd_addr_a (rs1_addr),
        .i_rd_addr_b (rs2_addr),
        .o_rd_busy_a (w_rs1_busy),
        .o_rd_busy_b (w_rs2_busy),
        .o_busy      (busy)
    );

`ifdef REGFILE_WB_FWD_EN
    // A source whose MDU result is on the write port this cycle can bypass it
    assign rs1_fwd     = w_rs1_busy && w_clr_en && (w_clr_addr == rs1_addr);
    assign rs2_fwd     = w_rs2_busy && w_clr_en && (w_clr_addr == rs2_addr);
    assign w_rs1_stall = w_rs1_busy && !rs1_fwd;
    assign w_rs2_stall = w_rs2_busy && !rs2_fwd;
`else
    assign w_rs1_stall = w_rs1_busy;
    assign w_rs2_stall = w_rs2_busy;
`endif

    assign stall = !CPU_rst && (w_rs1_stall || w_rs2_stall ||
                                (main_we && busy[main_rd]) ||
                                (mdu_issue && busy[mdu_issue_rd]));

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// Bench for regfile_wb_arbiter: directed vector table followed by random
// traffic checked against a queue-based model of the arbitration rules.
module tb_regfile_wb_arbiter;

    localparam int W   = 32;
    localparam int RC  = 32;
    localparam int LIM = 4;

    logic        CPU_clk = 1'b0;
    logic        CPU_rst;
    logic        main_we;
    logic [4:0]  main_rd;
    logic [31:0] main_wdata;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_wdata;
    logic        mdu_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        stall;
    logic        wb_hold;
    logic        RegWrite;
    logic [4:0]  RdAddr;
    logic [31:0] WriteData;
    logic [31:0] busy;
`ifdef REGFILE_WB_FWD_EN
    logic        rs1_fwd;
    logic        rs2_fwd;
`endif

    always #5 CPU_clk = ~CPU_clk;

    regfile_wb_arbiter #(
        .WIDTH        (W),
        .REG_COUNT    (RC),
        .STARVE_LIMIT (LIM)
    ) dut (
        .CPU_clk      (CPU_clk),
        .CPU_rst      (CPU_rst),
        .main_we      (main_we),
        .main_rd      (main_rd),
        .main_wdata   (main_wdata),
        .mdu_issue    (mdu_issue),
        .mdu_issue_rd (mdu_issue_rd),
        .mdu_valid    (mdu_valid),
        .mdu_rd       (mdu_rd),
        .mdu_wdata    (mdu_wdata),
        .mdu_ready    (mdu_ready),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .stall        (stall),
        .wb_hold      (wb_hold),
        .RegWrite     (RegWrite),
        .RdAddr       (RdAddr),
        .WriteData    (WriteData),
        .busy         (busy)
`ifdef REGFILE_WB_FWD_EN
        ,
        .rs1_fwd      (rs1_fwd),
        .rs2_fwd      (rs2_fwd)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int rst, mwe, mrd, mwd, iss, ird, mv, mdrd, mdd, rs1, rs2;
        int erw, erd, ewd, erdy, estall, ehold, ebusy;
    } vec_t;
    vec_t vt[$];

    task automatic add_vec(input int rst, mwe, mrd, mwd, iss, ird, mv, mdrd, mdd, rs1, rs2,
                           input int erw, erd, ewd, erdy, estall, ehold, ebusy);
        vec_t v;
        v.rst = rst; v.mwe = mwe; v.mrd = mrd; v.mwd = mwd; v.iss = iss; v.ird = ird;
        v.mv = mv; v.mdrd = mdrd; v.mdd = mdd; v.rs1 = rs1; v.rs2 = rs2;
        v.erw = erw; v.erd = erd; v.ewd = ewd; v.erdy = erdy; v.estall = estall;
        v.ehold = ehold; v.ebusy = ebusy;
        vt.push_back(v);
    endtask

    task automatic drive(input bit r, mwe, input int mrd, input logic [31:0] mwd,
                         input bit iss, input int ird, input bit mv, input int mdrd,
                         input logic [31:0] mdd, input int r1, r2);
        CPU_rst      = r;
        main_we      = mwe;
        main_rd      = 5'(mrd);
        main_wdata   = mwd;
        mdu_issue    = iss;
        mdu_issue_rd = 5'(ird);
        mdu_valid    = mv;
        mdu_rd       = 5'(mdrd);
        mdu_wdata    = mdd;
        rs1_addr     = 5'(r1);
        rs2_addr     = 5'(r2);
    endtask

    // Reference model state
    logic [31:0] m_busy;
    int          m_bq_rd[$];
    logic [31:0] m_bq_d[$];
    int          m_denied;
    bit          m_hold_prev;

    bit          g_rst, g_mwe, g_iss, g_mv;
    int          g_mrd, g_ird, g_mdrd, g_rs1, g_rs2;
    logic [31:0] g_mwd, g_mdd;
    bit          x_rdy, x_mw, x_rw, x_stall, x_hold;
    int          x_rd, x_clr;
    logic [31:0] x_wd;
    int          cand[$];

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CPU_clk);
        #1;

        // reset
        add_vec(1, 1, 3, 'h55, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        // direct MDU write
        add_vec(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0,      0, 0, 0, 1, 1, 0, 'h20);
        add_vec(0, 0, 0, 0, 0, 0, 1, 5, 'hDEADBEEF, 5, 0, 1, 5, 'hDEADBEEF, 1, 1, 0, 'h20);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0,      0, 0, 0, 1, 0, 0, 0);
        // collision
        add_vec(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        add_vec(0, 1, 3, 'h11, 0, 0, 1, 7, 'h22, 0, 0, 1, 3, 'h11, 1, 0, 0, 'h80);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 7, 'h22, 0, 0, 0, 'h80);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        // starvation
        add_vec(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        add_vec(0, 1, 1, 'hA1, 0, 0, 1, 9, 'h99, 0, 0, 1, 1, 'hA1, 1, 0, 0, 'h200);
        add_vec(0, 1, 2, 'hA2, 0, 0, 0, 0, 0, 0, 0,   1, 2, 'hA2, 0, 0, 0, 'h200);
        add_vec(0, 1, 2, 'hA2, 0, 0, 0, 0, 0, 0, 0,   1, 2, 'hA2, 0, 0, 0, 'h200);
        add_vec(0, 1, 2, 'hA2, 0, 0, 0, 0, 0, 0, 0,   1, 2, 'hA2, 0, 0, 0, 'h200);
        add_vec(0, 1, 2, 'hA2, 0, 0, 0, 0, 0, 0, 0,   1, 2, 'hA2, 0, 0, 1, 'h200);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 9, 'h99, 0, 0, 0, 'h200);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        // x0 handling
        add_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        add_vec(0, 1, 0, 'h77, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        add_vec(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        add_vec(0, 1, 6, 'h66, 0, 0, 1, 4, 'h44, 0, 0, 1, 6, 'h66, 1, 0, 0, 'h10);
        add_vec(0, 1, 0, 'h77, 0, 0, 0, 0, 0, 0, 0,   1, 4, 'h44, 0, 0, 0, 'h10);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        // reset mid-operation
        add_vec(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        add_vec(0, 1, 3, 'h33, 0, 0, 1, 7, 'h70, 0, 0, 1, 3, 'h33, 1, 0, 0, 'h80);
        add_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 'h80);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        // WAW and issue-side hazards
        add_vec(0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        add_vec(0, 1, 8, 'h88, 0, 0, 0, 0, 0, 0, 0,   1, 8, 'h88, 1, 1, 0, 'h100);
        add_vec(0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0,      0, 0, 0, 1, 1, 0, 'h100);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8,      0, 0, 0, 1, 1, 0, 'h100);
        add_vec(0, 0, 0, 0, 0, 0, 1, 8, 'h80, 0, 0,   1, 8, 'h80, 1, 0, 0, 'h100);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);

        foreach (vt[i]) begin
            drive(vt[i].rst[0], vt[i].mwe[0], vt[i].mrd, vt[i].mwd, vt[i].iss[0], vt[i].ird,
                  vt[i].mv[0], vt[i].mdrd, vt[i].mdd, vt[i].rs1, vt[i].rs2);
            #4;
            chk($sformatf("v%0d.RegWrite", i), {31'd0, RegWrite}, vt[i].erw);
            if (vt[i].erw != 0) begin
                chk($sformatf("v%0d.RdAddr", i), {27'd0, RdAddr}, vt[i].erd);
                chk($sformatf("v%0d.WriteData", i), WriteData, vt[i].ewd);
            end
            chk($sformatf("v%0d.mdu_ready", i), {31'd0, mdu_ready}, vt[i].erdy);
            chk($sformatf("v%0d.stall", i), {31'd0, stall}, vt[i].estall);
            chk($sformatf("v%0d.wb_hold", i), {31'd0, wb_hold}, vt[i].ehold);
            chk($sformatf("v%0d.busy", i), busy, vt[i].ebusy);
            @(posedge CPU_clk);
            #1;
        end

        // Random traffic; the table leaves the block idle with nothing busy
        m_busy      = '0;
        m_denied    = 0;
        m_hold_prev = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            g_rst = ($urandom_range(0, 99) == 0);
            g_mwe = m_hold_prev ? 1'b0 : 1'($urandom_range(0, 1));
            g_mrd = $urandom_range(0, 31);
            g_mwd = $urandom;
            g_ird = $urandom_range(0, 31);
            g_iss = ($urandom_range(0, 2) == 0) && !m_busy[g_ird];
            g_rs1 = $urandom_range(0, 31);
            g_rs2 = $urandom_range(0, 31);
            g_mdd = $urandom;
            cand.delete();
            for (int k = 1; k < 32; k++) begin
                if (m_busy[k] && !(m_bq_rd.size() > 0 && m_bq_rd[0] == k)) cand.push_back(k);
            end
            g_mv   = (cand.size() > 0) && ($urandom_range(0, 1) == 1);
            g_mdrd = (cand.size() > 0) ? cand[$urandom_range(0, cand.size() - 1)] : 0;

            x_rdy = (m_bq_rd.size() == 0) && !g_rst;
            x_mw  = g_mwe && (g_mrd != 0) && !g_rst;
            x_rw  = 1'b0;
            x_rd  = 0;
            x_wd  = '0;
            x_clr = -1;
            if (g_rst) begin
                x_rw = 1'b0;
            end else if (x_mw) begin
                x_rw = 1'b1; x_rd = g_mrd; x_wd = g_mwd;
            end else if (m_bq_rd.size() > 0) begin
                x_rw = 1'b1; x_rd = m_bq_rd[0]; x_wd = m_bq_d[0]; x_clr = x_rd;
            end else if (g_mv && x_rdy && g_mdrd != 0) begin
                x_rw = 1'b1; x_rd = g_mdrd; x_wd = g_mdd; x_clr = x_rd;
            end
            x_stall = !g_rst && (m_busy[g_rs1] || m_busy[g_rs2] ||
                                 (g_mwe && m_busy[g_mrd]) || (g_iss && m_busy[g_ird]));
            x_hold  = !g_rst && (m_bq_rd.size() > 0) && x_mw && (m_denied >= LIM - 1);

            drive(g_rst, g_mwe, g_mrd, g_mwd, g_iss, g_ird, g_mv, g_mdrd, g_mdd, g_rs1, g_rs2);
            #4;
            chk("rnd.RegWrite", {31'd0, RegWrite}, {31'd0, x_rw});
            if (x_rw) begin
                chk("rnd.RdAddr", {27'd0, RdAddr}, x_rd);
                chk("rnd.WriteData", WriteData, x_wd);
            end
            chk("rnd.mdu_ready", {31'd0, mdu_ready}, {31'd0, x_rdy});
            chk("rnd.stall", {31'd0, stall}, {31'd0, x_stall});
            chk("rnd.wb_hold", {31'd0, wb_hold}, {31'd0, x_hold});
            chk("rnd.busy", busy, m_busy);
            @(posedge CPU_clk);
            #1;

            if (g_rst) begin
                m_busy   = '0;
                m_denied = 0;
                m_bq_rd.delete();
                m_bq_d.delete();
            end else begin
                if (x_clr >= 0) m_busy[x_clr] = 1'b0;
                if (g_iss && g_ird != 0) m_busy[g_ird] = 1'b1;
                if (m_bq_rd.size() > 0) begin
                    if (!x_mw) begin
                        void'(m_bq_rd.pop_front());
                        void'(m_bq_d.pop_front());
                        m_denied = 0;
                    end else if (m_denied < LIM) begin
                        m_denied++;
                    end
                end else if (g_mv && x_rdy && g_mdrd != 0 && x_mw) begin
                    m_bq_rd.push_back(g_mdrd);
                    m_bq_d.push_back(g_mdd);
                end
            end
            m_hold_prev = x_hold;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the RV32IM general-purpose register file. It shares the file's single write port between the single-cycle pipeline writeback and the multi-cycle M-extension unit (MDU), using a one-entry holding buffer for a deferred MDU result. It tracks registers with an outstanding MDU result and raises pipeline stall on RAW/WAW hazards against them. It sits between the writeback mux, the MDU and `Register_File`, and drives that file's `RegWrite`, `RdAddr` and `WriteData`.

## Interface
Parameters:
- `WIDTH`, 32, data width.
- `REG_COUNT`, 32, number of architectural registers. Address width `AW = $clog2(REG_COUNT)`.
- `STARVE_LIMIT`, 4, consecutive cycles a buffered MDU result may be denied before the arbiter forces a writeback bubble.

Ports:
- `CPU_clk`  in  1  clock; all state updates on rising edge.
- `CPU_rst`  in  1  reset, synchronous and active-high.
- `main_we`  in  1  pipeline writeback request.
- `main_rd`  in  AW  pipeline destination register.
- `main_wdata`  in  WIDTH  pipeline write data.
- `mdu_issue`  in  1  MDU op issued this cycle; claims `mdu_issue_rd`.
- `mdu_issue_rd`  in  AW  destination of the issued MDU op.
- `mdu_valid`  in  1  MDU result available.
- `mdu_rd`  in  AW  MDU result destination.
- `mdu_wdata`  in  WIDTH  MDU result data.
- `mdu_ready`  out  1  arbiter accepts the MDU result this cycle.
- `rs1_addr`, `rs2_addr`  in  AW  decode-stage source registers.
- `stall`  out  1  hazard; the pipeline must hold decode and issue nothing.
- `wb_hold`  out  1  starvation; the pipeline must keep `main_we` low next cycle.
- `RegWrite`  out  1  register-file write enable.
- `RdAddr`  out  AW  register-file write address.
- `WriteData`  out  WIDTH  register-file write data.
- `busy`  out  REG_COUNT  scoreboard vector, for debug and verification.

## Operation
- A request to x0 is a non-request. `main_we` with `main_rd==0` never writes. `mdu_issue` with rd 0 sets no busy bit.
- Write grant priority: main, then buffered MDU, then direct MDU.
  - Main is never stalled by the arbiter.
- MDU result acceptance:
  - `mdu_ready = !buf_valid && !CPU_rst`. A result transfers when `mdu_valid && mdu_ready`.
  - If a result transfers while main writes, it is captured into the buffer (`buf_valid` ← 1).
  - Otherwise it is written directly in the same cycle.
- Buffer drain: the buffer is written on any cycle with no effective main write; `buf_valid` then clears.
- Scoreboard, per bit:
  - Set by `mdu_issue` (rd≠0).
  - Cleared on the cycle its MDU result is granted to the write port. Being buffered does not clear it.
  - Set and clear on the same bit in the same cycle is illegal; it is prevented by `stall`.
- `stall` = `busy[rs1_addr]` | `busy[rs2_addr]` | (`main_we` & `busy[main_rd]`) | (`mdu_issue` & `busy[mdu_issue_rd]`). Index 0 is always 0.
- Starvation counter:
  - Increments on each cycle `buf_valid` is set and main wins. Clears when the buffer drains.
  - `wb_hold` = (count ≥ `STARVE_LIMIT`−1) && `buf_valid` && main winning.
  - The counter saturates at `STARVE_LIMIT`.
- Reset mid-operation clears `busy`, `buf_valid` and the counter. A buffered or in-flight MDU result is lost; the MDU is reset by the same `CPU_rst`.

## Timing
- Reset values: `busy`=0, `buf_valid`=0, counter 0, `RegWrite`=0, `mdu_ready`=0, `stall`=0, `wb_hold`=0.
- `RegWrite`/`RdAddr`/`WriteData` are combinational from the current requests and the buffer. The register file commits at the next edge.
- Direct MDU latency: 0 cycles to grant, data visible in the register file the next cycle.
- Buffered latency: 1 to `STARVE_LIMIT`+1 cycles.
- The busy bit drops one edge after the grant. `stall` for that register deasserts in that next cycle (no forwarding).

## Configuration
- `REGFILE_WB_FWD_EN` defined:
  - Adds outputs `rs1_fwd`, `rs2_fwd` (1 bit each).
  - A busy register whose MDU result is granted this cycle is forwarded from `WriteData` and does not contribute to `stall`.
- Undefined: no forward outputs; `stall` as above.

## Structure
- Package `regfile_pkg`: `REG_COUNT`, `AW`, `X0_ADDR`, default `STARVE_LIMIT`, and the write-source enum (`WB_NONE`, `WB_MAIN`, `WB_BUF`, `WB_MDU`).
- Sub-module `regfile_scoreboard`: busy vector with set/clear ports and two read-port lookups. Arbitration, buffer and starvation logic live in the top module.

## Test plan
- Reset:
  - While `CPU_rst`=1, `mdu_ready`=0 and `RegWrite`=0.
  - After release, `mdu_ready`=1 and `busy`=0.
- Direct MDU write:
  - Issue rd=5, then `rs1_addr`=5 → `stall`=1.
  - `mdu_valid` rd=5 data 0xDEADBEEF with `main_we`=0 → `RegWrite`=1, `RdAddr`=5.
  - Next cycle `busy[5]`=0 and `stall`=0.
- Collision:
  - Main x3=0x11 and MDU x7=0x22 in the same cycle → x3 written, buffer captures, `mdu_ready`=0.
  - Next idle cycle → x7=0x22 written, `busy[7]` clears.
- Starvation, `STARVE_LIMIT`=4: buffer full and `main_we`=1 continuously → `wb_hold`=1 in the 4th cycle; buffer drains the cycle after.
- x0 handling:
  - `mdu_issue` rd=0 → `busy` unchanged.
  - `main_we` rd=0 → `RegWrite`=0; a pending MDU result drains that cycle.
- Reset mid-op: buffer full and `busy[7]`=1, assert `CPU_rst` for one edge → `busy`=0, `buf_valid`=0, `mdu_ready`=1 after release.
